pipeline_chain: RTL and testbench

- Parametrised multi-stage register chain for the DSP48A1-style datapath.
- Generalises the single-register pipeline mux to `DEPTH` stages; the output latency is selected at run time through a tap index.
- A valid bit travels alongside the data. The chain supports stall (clock enable), a synchronous flush, and an optional occupancy counter.
- Sits between operand input ports and the pre-adder/multiplier stages wherever configurable operand latency is needed.

---
 rtl/pipeline_chain.sv | 100 ++++++++++
 tb/tb_pipeline_chain.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_chain.sv
// Configurable-latency register chain with valid bit, stall, flush and tap mux.
// Optional occupancy counter is enabled by defining PIPE_CHAIN_OCC_EN.
module pipeline_chain #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4,
   parameter int SELW  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] in_i,
   input  logic             in_vld_i,
   input  logic [SELW-1:0]  sel_i,
`ifdef PIPE_CHAIN_OCC_EN
   output logic [SELW-1:0]  occ_o,
`endif
   output logic [WIDTH-1:0] out_o,
   output logic             out_vld_o
);

   logic [WIDTH-1:0] s_q [1:DEPTH];
   logic [WIDTH-1:0] s_d [1:DEPTH];
   logic [DEPTH:1]   v_q;
   logic [DEPTH:1]   v_d;
   logic [SELW-1:0]  tap;

   // Flush outranks enable; the sample presented with clr is dropped.
   always_comb begin
      s_d = s_q;
      v_d = v_q;
      if (clr_i) begin
         for (int k = 1; k <= DEPTH; k++) begin
            s_d[k] = '0;
         end
         v_d = '0;
      end else if (en_i) begin
         s_d[1] = in_i;
         v_d[1] = in_vld_i;
         for (int k = 2; k <= DEPTH; k++) begin
            s_d[k] = s_q[k-1];
            v_d[k] = v_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 1; k <= DEPTH; k++) begin
            s_q[k] <= '0;
         end
         v_q <= '0;
      end else begin
         s_q <= s_d;
         v_q <= v_d;
      end
   end

   always_comb begin
      tap = sel_i;
      if (sel_i > SELW'(DEPTH)) begin
         tap = SELW'(DEPTH);
      end
   end

   // Tap 0 is the bypass; every other tap reads a stage register.
   always_comb begin
      out_o     = in_i;
      out_vld_o = in_vld_i;
      for (int k = 1; k <= DEPTH; k++) begin
         if (tap == SELW'(k)) begin
            out_o     = s_q[k];
            out_vld_o = v_q[k];
         end
      end
   end

`ifdef PIPE_CHAIN_OCC_EN
   logic [SELW-1:0] occ_q;
   logic [SELW-1:0] occ_d;

   always_comb begin
      occ_d = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         occ_d = occ_d + SELW'(v_d[k]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ_o = occ_q;
`endif

endmodule

// File: tb/tb_pipeline_chain.sv
// Directed bench for pipeline_chain: WIDTH=4, DEPTH=4, SELW=4.
module tb_pipeline_chain;

   logic       clk;
   logic       rst;
   logic       en;
   logic       clr;
   logic [3:0] din;
   logic       din_vld;
   logic [3:0] sel;
   logic [3:0] dout;
   logic       dout_vld;
`ifdef PIPE_CHAIN_OCC_EN
   logic [3:0] occ;
`endif

   int passed = 0;
   int total  = 0;

   pipeline_chain #(.WIDTH(4), .DEPTH(4), .SELW(4)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .clr_i     (clr),
      .in_i      (din),
      .in_vld_i  (din_vld),
      .sel_i     (sel),
`ifdef PIPE_CHAIN_OCC_EN
      .occ_o     (occ),
`endif
      .out_o     (dout),
      .out_vld_o (dout_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; clr = 1'b0;
      din = 4'h3; din_vld = 1'b1; sel = 4'd4;
      step();
      step();
      total++;
      if (dout !== 4'h0) $display("FAIL reset_out: got %h want 0", dout);
      else passed++;
      total++;
      if (dout_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", dout_vld);
      else passed++;
`ifdef PIPE_CHAIN_OCC_EN
      total++;
      if (occ !== 4'd0) $display("FAIL reset_occ: got %0d want 0", occ);
      else passed++;
`endif
      rst = 1'b0;
   endtask

   // in=1..8 at sel=4: zero for edges 1..3, then edge n shows n-3
   task automatic test_latency();
      logic [3:0] exp;
      sel = 4'd4; en = 1'b1; din_vld = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         din = 4'(i);
         step();
         exp = (i >= 4) ? 4'(i - 3) : 4'h0;
         total++;
         if (dout !== exp)
            $display("FAIL latency_out edge%0d: got %h want %h", i, dout, exp);
         else passed++;
         total++;
         if (dout_vld !== (i >= 4))
            $display("FAIL latency_vld edge%0d: got %b want %b", i, dout_vld, (i >= 4));
         else passed++;
      end
   endtask

   // chain holds s1..s4 = 8,7,6,5 here
   task automatic test_clamp();
      en = 1'b0;
      sel = 4'd7;
      #1;
      total++;
      if (dout !== 4'h5) $display("FAIL clamp_sel7: got %h want 5", dout);
      else passed++;
      sel = 4'd15;
      #1;
      total++;
      if (dout !== 4'h5) $display("FAIL clamp_sel15: got %h want 5", dout);
      else passed++;
      sel = 4'd2;
      #1;
      total++;
      if (dout !== 4'h7) $display("FAIL tap2: got %h want 7", dout);
      else passed++;
      sel = 4'd1;
      #1;
      total++;
      if (dout !== 4'h8) $display("FAIL tap1: got %h want 8", dout);
      else passed++;
   endtask

   task automatic test_bypass();
      sel = 4'd0; din = 4'hA; din_vld = 1'b1; en = 1'b0;
      #1;
      total++;
      if (dout !== 4'hA) $display("FAIL bypass_en0: got %h want a", dout);
      else passed++;
      en = 1'b1;
      #1;
      total++;
      if (dout !== 4'hA) $display("FAIL bypass_en1: got %h want a", dout);
      else passed++;
      din = 4'h5; din_vld = 1'b0; en = 1'b0;
      #1;
      total++;
      if (dout !== 4'h5 || dout_vld !== 1'b0)
         $display("FAIL bypass_vld: got %h/%b want 5/0", dout, dout_vld);
      else passed++;
   endtask

   // chain still 8,7,6,5; tap 2 reads 7 through a 3-cycle stall
   task automatic test_stall();
      logic [3:0] exp [3];
      exp[0] = 4'h8; exp[1] = 4'h5; exp[2] = 4'h6;
      sel = 4'd2; en = 1'b0; din_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 4'(i + 12);
         step();
         total++;
         if (dout !== 4'h7)
            $display("FAIL stall_hold cyc%0d: got %h want 7", i, dout);
         else passed++;
      end
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 4'(i + 5);
         step();
         total++;
         if (dout !== exp[i] || dout_vld !== 1'b1)
            $display("FAIL stall_resume edge%0d: got %h/%b want %h/1",
                     i + 1, dout, dout_vld, exp[i]);
         else passed++;
      end
   endtask

   // chain holds 7,6,5,8 all valid
   task automatic test_flush();
      clr = 1'b1; en = 1'b1; din = 4'hF; din_vld = 1'b1;
      step();
      clr = 1'b0; en = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         sel = 4'(t);
         #1;
         total++;
         if (dout !== 4'h0 || dout_vld !== 1'b0)
            $display("FAIL flush_tap%0d: got %h/%b want 0/0", t, dout, dout_vld);
         else passed++;
      end
`ifdef PIPE_CHAIN_OCC_EN
      total++;
      if (occ !== 4'd0) $display("FAIL flush_occ: got %0d want 0", occ);
      else passed++;
`endif
      en = 1'b1; din = 4'h3;
      step();
      sel = 4'd1;
      #1;
      total++;
      if (dout !== 4'h3) $display("FAIL flush_refill1: got %h want 3", dout);
      else passed++;
      sel = 4'd2;
      #1;
      total++;
      if (dout !== 4'h0 || dout_vld !== 1'b0)
         $display("FAIL flush_no_f: got %h/%b want 0/0", dout, dout_vld);
      else passed++;
   endtask

   task automatic test_async_reset();
      sel = 4'd4; en = 1'b1; din_vld = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         din = 4'(i + 8);
         step();
      end
      total++;
      if (dout !== 4'h9 || dout_vld !== 1'b1)
         $display("FAIL areset_full: got %h/%b want 9/1", dout, dout_vld);
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (dout !== 4'h0 || dout_vld !== 1'b0)
         $display("FAIL areset_tap4: got %h/%b want 0/0", dout, dout_vld);
      else passed++;
      sel = 4'd1;
      #1;
      total++;
      if (dout !== 4'h0 || dout_vld !== 1'b0)
         $display("FAIL areset_tap1: got %h/%b want 0/0", dout, dout_vld);
      else passed++;
`ifdef PIPE_CHAIN_OCC_EN
      total++;
      if (occ !== 4'd0) $display("FAIL areset_occ: got %0d want 0", occ);
      else passed++;
`endif
      step();
      #2;
      rst = 1'b0;
   endtask

   task automatic test_bubbles();
      logic       vpat [4];
      logic [3:0] ovd  [4];
      logic [3:0] occx [4];
      logic       ovx  [4];
      vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b1; vpat[3] = 1'b1;
      occx[0] = 4'd1; occx[1] = 4'd1; occx[2] = 4'd2; occx[3] = 4'd3;
      ovd[0] = 4'h9; ovd[1] = 4'hA; ovd[2] = 4'hB; ovd[3] = 4'hC;
      ovx[0] = 1'b1; ovx[1] = 1'b0; ovx[2] = 1'b1; ovx[3] = 1'b1;
      sel = 4'd4; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = 4'(i + 9);
         din_vld = vpat[i];
         step();
`ifdef PIPE_CHAIN_OCC_EN
         total++;
         if (occ !== occx[i])
            $display("FAIL bubble_occ edge%0d: got %0d want %0d", i + 1, occ, occx[i]);
         else passed++;
`endif
      end
      din = 4'h0; din_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         total++;
         if (dout_vld !== ovx[i] || dout !== ovd[i])
            $display("FAIL bubble_out edge%0d: got %h/%b want %h/%b",
                     i + 4, dout, dout_vld, ovd[i], ovx[i]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_clamp();
      test_bypass();
      test_stall();
      test_flush();
      test_async_reset();
      test_bubbles();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
